// File: rtl/fwd_hazard_tracker.sv
// Forwarding-select and load-use stall generator that tracks in-flight destinations itself.
// The FWD_HAZARD_STATS_EN macro adds saturating stall and forward event counters.
module fwd_hazard_tracker #(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    localparam int SW       = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    output logic                      stall,
    output logic                      ex_valid,
`ifdef FWD_HAZARD_STATS_EN
    output logic [NUM_SRC*SW-1:0]     ex_fwd_sel,
    output logic [31:0]               stat_stall_cnt,
    output logic [31:0]               stat_fwd_cnt
`else
    output logic [NUM_SRC*SW-1:0]     ex_fwd_sel
`endif
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } entry_t;

    // sb[0] is the instruction now in EX; sb[j] is j stages further down.
    entry_t                  sb [FWD_DEPTH];
    logic [NUM_SRC*SW-1:0]   sel_next;
    logic [NUM_SRC-1:0]      load_hit;
    logic                    adv;

    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sel_next = '0;
        load_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Oldest to youngest, so the youngest matching producer overwrites the rest.
            for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
                if (sb[j].valid && (sb[j].rd == id_rs[i*REG_AW +: REG_AW]) &&
                    (id_rs[i*REG_AW +: REG_AW] != '0)) begin
                    sel_next[i*SW +: SW] = SW'(j + 1);
                    load_hit[i]          = sb[j].is_load && (j < LOAD_LAT);
                end
            end
        end
    end

    assign stall = id_valid && !flush && (|load_hit);
    assign adv   = id_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; the shift below relies on that ordering.
        if (rst) begin
            // NOTE: the scoreboard is reset, not just left to age out, because a
            // stale valid bit would create false forwards and stalls after reset.
            for (int j = 0; j < FWD_DEPTH; j++) begin
                sb[j] <= '0;
            end
            ex_valid   <= 1'b0;
            ex_fwd_sel <= '0;
        end else if (!hold) begin
            sb[0].valid   <= adv && id_reg_write && (id_rd != '0);
            sb[0].rd      <= id_rd;
            sb[0].is_load <= id_mem_read;
            for (int j = 1; j < FWD_DEPTH; j++) begin
                sb[j] <= sb[j-1];
            end
            ex_valid   <= adv;
            ex_fwd_sel <= adv ? sel_next : '0;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else if (!hold) begin
            if (stall && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
            if (adv && (|sel_next) && (stat_fwd_cnt != '1)) begin
                stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed bench for fwd_hazard_tracker: a vector table plus hand-written
// hold / flush / reset / deep-pipeline sequences.
module tb_fwd_hazard_tracker;

    logic       clk = 1'b0;
    logic       rst, hold, flush, id_valid, id_reg_write, id_mem_read;
    logic [9:0] id_rs;
    logic [4:0] id_rd;
    logic       stall, ex_valid, stall3, ex_valid3;
    logic [3:0] ex_fwd_sel, ex_fwd_sel3;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stat_stall_cnt, stat_fwd_cnt, stat_stall_cnt3, stat_fwd_cnt3;
`endif

    fwd_hazard_tracker dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .stall(stall), .ex_valid(ex_valid),
`ifdef FWD_HAZARD_STATS_EN
        .ex_fwd_sel(ex_fwd_sel), .stat_stall_cnt(stat_stall_cnt), .stat_fwd_cnt(stat_fwd_cnt)
`else
        .ex_fwd_sel(ex_fwd_sel)
`endif
    );

    fwd_hazard_tracker #(.FWD_DEPTH(3), .LOAD_LAT(2)) dut3 (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .stall(stall3), .ex_valid(ex_valid3),
`ifdef FWD_HAZARD_STATS_EN
        .ex_fwd_sel(ex_fwd_sel3), .stat_stall_cnt(stat_stall_cnt3), .stat_fwd_cnt(stat_fwd_cnt3)
`else
        .ex_fwd_sel(ex_fwd_sel3)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int h, f, v, rs0, rs1, rd, rw, mr;
        int es, ev, s0, s1;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic apply(input int h, input int f, input int v, input int rs0, input int rs1,
                         input int rd, input int rw, input int mr);
        hold         = 1'(h);
        flush        = 1'(f);
        id_valid     = 1'(v);
        id_rs        = {5'(rs1), 5'(rs0)};
        id_rd        = 5'(rd);
        id_reg_write = 1'(rw);
        id_mem_read  = 1'(mr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the combinational stall before the edge, then the EX registers after it.
    task automatic step(input string name, input int es, input int ev, input int s0, input int s1);
        #1;
        check($sformatf("%s.stall", name), 32'(stall), es);
        tick();
        check($sformatf("%s.ex_valid", name), 32'(ex_valid), ev);
        check($sformatf("%s.sel0", name), 32'(ex_fwd_sel[1:0]), s0);
        check($sformatf("%s.sel1", name), 32'(ex_fwd_sel[3:2]), s1);
    endtask

    task automatic step3(input string name, input int es, input int ev, input int s0, input int s1);
        #1;
        check($sformatf("%s.stall3", name), 32'(stall3), es);
        tick();
        check($sformatf("%s.ex_valid3", name), 32'(ex_valid3), ev);
        check($sformatf("%s.sel0_3", name), 32'(ex_fwd_sel3[1:0]), s0);
        check($sformatf("%s.sel1_3", name), 32'(ex_fwd_sel3[3:2]), s1);
    endtask

    task automatic do_reset(input string name);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        check($sformatf("%s.rst_ex_valid", name), 32'(ex_valid), 0);
        check($sformatf("%s.rst_sel", name), 32'(ex_fwd_sel), 0);
        check($sformatf("%s.rst_stall", name), 32'(stall), 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        //            h f v rs0 rs1 rd rw mr   es ev s0 s1
        vecs[0]  = '{0,0,0,  0,  0, 0, 0, 0,   0, 0, 0, 0};  // idle
        vecs[1]  = '{0,0,1,  1,  2, 3, 1, 0,   0, 1, 0, 0};  // add r3
        vecs[2]  = '{0,0,1,  3,  4, 8, 1, 0,   0, 1, 1, 0};  // sub uses r3 at distance 1
        vecs[3]  = '{0,0,1,  0,  0, 5, 1, 1,   0, 1, 0, 0};  // lw r5
        vecs[4]  = '{0,0,1,  5,  9,10, 1, 0,   1, 0, 0, 0};  // load-use stall
        vecs[5]  = '{0,0,1,  5,  9,10, 1, 0,   0, 1, 2, 0};  // released, distance 2
        vecs[6]  = '{0,0,1,  1,  2, 7, 1, 0,   0, 1, 0, 0};  // add r7
        vecs[7]  = '{0,0,1,  1,  2, 7, 1, 0,   0, 1, 0, 0};  // add r7 again
        vecs[8]  = '{0,0,1,  7,  7,11, 1, 0,   0, 1, 1, 1};  // youngest wins, both srcs equal
        vecs[9]  = '{0,0,1,  1,  2, 0, 1, 0,   0, 1, 0, 0};  // write to r0, not recorded
        vecs[10] = '{0,0,1,  0, 11,12, 1, 0,   0, 1, 0, 2};  // r0 never matches; r11 at distance 2
        vecs[11] = '{0,0,1,  1,  2, 6, 1, 1,   0, 1, 0, 0};  // lw r6
        vecs[12] = '{0,0,1,  1,  2,13, 1, 0,   0, 1, 0, 0};  // independent
        vecs[13] = '{0,0,1,  6, 13,14, 1, 0,   0, 1, 2, 1};  // load at distance 2, no stall
        vecs[14] = '{0,1,1,  1,  2,15, 1, 0,   0, 0, 0, 0};  // flushed instruction
        vecs[15] = '{0,0,1, 14,  0, 0, 0, 0,   0, 1, 2, 0};  // older entry still shifted

        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset("init");

        for (int k = 0; k < NV; k++) begin
            apply(vecs[k].h, vecs[k].f, vecs[k].v, vecs[k].rs0, vecs[k].rs1,
                  vecs[k].rd, vecs[k].rw, vecs[k].mr);
            step($sformatf("vec%0d", k), vecs[k].es, vecs[k].ev, vecs[k].s0, vecs[k].s1);
        end

        // Hold for three cycles in the middle of a load-use stall.
        do_reset("hold");
        apply(0, 0, 1, 0, 0, 5, 1, 1);
        step("hold.lw", 0, 1, 0, 0);
        apply(1, 0, 1, 5, 0, 10, 1, 0);
        for (int k = 0; k < 3; k++) step($sformatf("hold.h%0d", k), 1, 1, 0, 0);
        apply(0, 0, 1, 5, 0, 10, 1, 0);
        step("hold.stall", 1, 0, 0, 0);
        step("hold.release", 0, 1, 2, 0);

        // Flush while the load-use stall would be active.
        do_reset("flush");
        apply(0, 0, 1, 0, 0, 5, 1, 1);
        step("flush.lw", 0, 1, 0, 0);
        apply(0, 1, 1, 5, 0, 10, 1, 0);
        step("flush.kill", 0, 0, 0, 0);
        apply(0, 0, 1, 5, 0, 10, 1, 0);
        step("flush.after", 0, 1, 2, 0);

        // Reset asserted mid-stall.
        do_reset("rstmid");
        apply(0, 0, 1, 0, 0, 5, 1, 1);
        step("rstmid.lw", 0, 1, 0, 0);
        apply(0, 0, 1, 5, 0, 10, 1, 0);
        #1;
        check("rstmid.pre_stall", 32'(stall), 1);
        rst = 1'b1;
        tick();
        check("rstmid.ex_valid", 32'(ex_valid), 0);
        check("rstmid.sel", 32'(ex_fwd_sel), 0);
        check("rstmid.stall", 32'(stall), 0);
        rst = 1'b0;
        step("rstmid.after", 0, 1, 0, 0);

        // Deeper pipeline: FWD_DEPTH=3, LOAD_LAT=2.
        do_reset("deep");
        apply(0, 0, 1, 0, 0, 6, 1, 1);
        step3("deep.lw", 0, 1, 0, 0);
        apply(0, 0, 1, 0, 0, 13, 1, 0);
        step3("deep.indep", 0, 1, 0, 0);
        apply(0, 0, 1, 6, 13, 20, 1, 0);
        step3("deep.stall", 1, 0, 0, 0);
        step3("deep.release", 0, 1, 3, 2);
        apply(0, 0, 1, 0, 0, 9, 1, 1);
        step3("deep.lw9", 0, 1, 0, 0);
        apply(0, 0, 1, 0, 0, 9, 1, 0);
        step3("deep.add9", 0, 1, 0, 0);
        apply(0, 0, 1, 9, 0, 0, 0, 0);
        step3("deep.shadow", 0, 1, 1, 0);

        // Two load-use stalls and three forwarded instructions.
        do_reset("stats");
`ifdef FWD_HAZARD_STATS_EN
        check("stats.rst_stall_cnt", stat_stall_cnt, 0);
        check("stats.rst_fwd_cnt", stat_fwd_cnt, 0);
`endif
        apply(0, 0, 1, 0, 0, 5, 1, 1);
        step("stats.lw5", 0, 1, 0, 0);
        apply(0, 0, 1, 5, 0, 0, 0, 0);
        step("stats.use5_stall", 1, 0, 0, 0);
        step("stats.use5", 0, 1, 2, 0);
        apply(0, 0, 1, 0, 0, 6, 1, 1);
        step("stats.lw6", 0, 1, 0, 0);
        apply(0, 0, 1, 6, 0, 0, 0, 0);
        step("stats.use6_stall", 1, 0, 0, 0);
        step("stats.use6", 0, 1, 2, 0);
        apply(0, 0, 1, 0, 0, 3, 1, 0);
        step("stats.add3", 0, 1, 0, 0);
        apply(0, 0, 1, 3, 0, 0, 0, 0);
        step("stats.use3", 0, 1, 1, 0);
`ifdef FWD_HAZARD_STATS_EN
        check("stats.stall_cnt", stat_stall_cnt, 2);
        check("stats.fwd_cnt", stat_fwd_cnt, 3);
`endif

        apply(0, 0, 0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_tracker.md
Name: fwd_hazard_tracker

Overview:
- Parametrised successor to the MIPS pipeline forwarding unit.
- Keeps its own in-flight destination scoreboard instead of taking stage Rd/reg_write ports.
- Resolves forwarding at ID against NUM_SRC source operands and registers one select per source into EX.
- Generates the load-use stall for any load latency. Sits between the ID/EX pipeline register and the EX operand muxes.

Parameters:
REG_AW, 5, register address width; address 0 is hard-wired zero and never matches.
NUM_SRC, 2, source operands per instruction.
FWD_DEPTH, 2, forwarding distances supported (1 = EX/MEM result, 2 = MEM/WB result, ...); range 1..7.
LOAD_LAT, 1, extra cycles a load result lags an ALU result; range 0..FWD_DEPTH-1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
hold  in  1  global pipeline freeze (e.g. memory wait).
flush  in  1  kill the ID instruction and the EX-bound bubble (branch taken).
id_valid  in  1  ID holds a real instruction.
id_rs  in  NUM_SRC*REG_AW  source addresses; source i at [i*REG_AW +: REG_AW].
id_rd  in  REG_AW  destination of the ID instruction.
id_reg_write  in  1  ID instruction writes id_rd.
id_mem_read  in  1  ID instruction is a load.
stall  out  1  combinational; hold PC and IF/ID, insert bubble into EX.
ex_valid  out  1  registered; EX holds a real instruction.
ex_fwd_sel  out  NUM_SRC*SW  registered; SW = clog2(FWD_DEPTH+1). 0 = register-file value, k = result from forwarding distance k.

Behaviour:
- Scoreboard: FWD_DEPTH entries {valid, rd, is_load}; entry 0 = instruction now in EX, entry j = j stages further down.
- Advance condition adv = id_valid && !stall && !flush.
- Per cycle with hold=0:
  - entry[j] <= entry[j-1].
  - entry[0] <= {adv && id_reg_write && id_rd!=0, id_rd, id_mem_read}.
  - ex_valid <= adv.
  - ex_fwd_sel <= adv ? computed sel : 0.
- With hold=1: all state and registered outputs are frozen. stall is still computed but the pipeline ignores it.
- Match for source i at entry j: entry valid and rd == id_rs[i] and id_rs[i] != 0. The youngest match (smallest j) wins; older matches are ignored.
- Computed sel for source i = j+1 of the winning match (distance next cycle), else 0.
- stall = id_valid && !flush && (some source's winning match is a load at j < LOAD_LAT).
  - An older load shadowed by a younger ALU producer does not stall.
- Producers beyond distance FWD_DEPTH are not tracked. The register file provides write-before-read.
- Stall sequence: each stalled cycle shifts the scoreboard and puts a bubble in EX. The ID instruction re-evaluates every cycle. On release, sel reflects the now-older producer distance.
- Flush: entry[0] and EX outputs receive a bubble. Older entries still shift, since they are committed instructions.
- Both srcs equal: each gets the identical sel.
- rd == 0 writes are never recorded.
- Reset, including mid-stall or mid-hold:
  - All entries invalid.
  - ex_valid=0, ex_fwd_sel=0.
  - stall=0 from the next cycle, because no entries are valid.
  - rst has priority over hold and flush.

Optional Feature:
- Macro FWD_HAZARD_STATS_EN.
- Defined: adds outputs stat_stall_cnt (32) and stat_fwd_cnt (32).
  - stat_stall_cnt: +1 per cycle with stall=1 and hold=0.
  - stat_fwd_cnt: +1 per advancing instruction with any nonzero source sel.
  - Both saturate at 0xFFFFFFFF, clear on rst, freeze on hold.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- add r3 at ID, next cycle sub rs=r3,rt=r4 at ID -> after advance ex_fwd_sel src0=1, src1=0, stall=0.
- lw r5, then immediate user of r5 (LOAD_LAT=1) -> stall=1 for exactly 1 cycle, ex_valid=0 that cycle; on release src0 sel=2.
- add r7, add r7, then user of r7 -> sel=1 (youngest wins). Repeat with rs=r0 and a prior write to r0 -> sel=0, no record.
- lw r6, independent instr, user of r6 -> no stall, sel=2. Set LOAD_LAT=2, FWD_DEPTH=3 with the same sequence -> 1 stall cycle, then sel=3.
- hold=1 for 3 cycles mid load-use stall -> ex_valid/ex_fwd_sel/scoreboard unchanged; flush during stall -> ex_valid=0, stall=0. rst asserted mid-stall -> next cycle ex_valid=0, ex_fwd_sel=0, stall=0.
- FWD_HAZARD_STATS_EN defined: 2 load-use stalls + 3 forwarded instrs -> stat_stall_cnt=2, stat_fwd_cnt=3. Preload near 0xFFFFFFFF -> saturates.
